// File: rtl/cpu_trace_uart.sv
// Execution-trace transmitter: buffers retired (pc, inst) pairs in a FIFO and
// streams each as a 9-byte 8N1 UART frame (sync byte, pc, inst, MSB byte first).
module cpu_trace_uart #(
  parameter int         CLKS_PER_BIT = 16,
  parameter int         DEPTH        = 8,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      step_valid,
  input  logic [31:0]               pc_in,
  input  logic [31:0]               inst_in,
  input  logic                      clr_overflow,
  output logic                      txd,
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic                      overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LAST   = TW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [63:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [3:0]    byte_idx;
  logic [63:0]   shreg;
  logic [7:0]    tx_byte;
  logic [7:0]    cur_byte;
  logic          full;
  logic          empty;
  logic          bit_done;
  logic          frame_done;
  logic          pop;
  logic          push;

  // Byte 0 of every frame is the sync byte; bytes 1..8 come from the top of shreg.
  always_comb begin
    full       = (fifo_count == FULL_CNT);
    empty      = (fifo_count == '0);
    bit_done   = (timer == T_LAST);
    frame_done = (state == STOP) && bit_done && (byte_idx == 4'd8);
    pop        = !empty && ((state == IDLE) || frame_done);
    push       = step_valid && (!full || pop);
    cur_byte   = (byte_idx == 4'd0) ? SYNC_BYTE : shreg[63:56];
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {pc_in, inst_in};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
      if (step_valid && !push) overflow <= 1'b1;
      else if (clr_overflow)   overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      timer    <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shreg    <= '0;
      tx_byte  <= '0;
      txd      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state    <= START;
            shreg    <= mem[rd_ptr];
            byte_idx <= '0;
            timer    <= '0;
            txd      <= 1'b0;
          end
        end
        START: begin
          if (bit_done) begin
            timer   <= '0;
            bit_idx <= '0;
            state   <= DATA;
            txd     <= cur_byte[0];
            tx_byte <= {1'b0, cur_byte[7:1]};
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (bit_done) begin
            timer <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              txd     <= tx_byte[0];
              tx_byte <= {1'b0, tx_byte[7:1]};
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
            timer <= '0;
            if (byte_idx != 4'd8) begin
              // Leaving the sync byte does not consume shreg; later bytes do.
              if (byte_idx != 4'd0) shreg <= {shreg[55:0], 8'h00};
              byte_idx <= byte_idx + 1'b1;
              state    <= START;
              txd      <= 1'b0;
            end else if (pop) begin
              shreg    <= mem[rd_ptr];
              byte_idx <= '0;
              state    <= START;
              txd      <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
